// File: rtl/trace_collector_pkg.sv
// Shared record format for the commit-trace collector: type codes, sequence width
// and the 64-bit record layout.
package Trace_PKG;

    localparam int         SEQ_W  = 14;
    localparam logic [1:0] TR_REG = 2'b01;
    localparam logic [1:0] TR_MEM = 2'b10;

    typedef struct packed {
        logic [1:0]       rtype;
        logic [SEQ_W-1:0] seq;
        logic [47:0]      payload;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(
        input logic [1:0]       rtype,
        input logic [SEQ_W-1:0] seq,
        input logic [47:0]      payload
    );
        trace_rec_t rec;
        rec.rtype   = rtype;
        rec.seq     = seq;
        rec.payload = payload;
        return rec;
    endfunction

endpackage

// File: rtl/trace_collector_fifo.sv
// Dual-push / single-pop record FIFO. The caller never pushes more than the free
// slots allow, and push1 is only meaningful together with push0.
module trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int W      = 64,
    parameter int PUSH_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0,
    input  logic                     push1,
    input  logic [W-1:0]             din0,
    input  logic [W-1:0]             din1,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr;
    logic             push1_g;
    logic [1:0]       n_push;

    generate
        if (PUSH_W > 1) begin : g_dual
            assign push1_g = push1;
        end else begin : g_single
            logic unused_push1;
            assign unused_push1 = push1 ^ (^din1);
            assign push1_g      = 1'b0;
        end
    endgenerate

    assign wr_ptr_nx = wr_ptr + PTR_W'(1);
    assign n_push    = {1'b0, push0} + {1'b0, push1_g};

    always_ff @(posedge clk) begin
        if (push0)   mem[wr_ptr]    <= din0;
        if (push1_g) mem[wr_ptr_nx] <= din1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            level  <= level + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
        end
    end

    assign valid = (level != '0);
    assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/trace_collector.sv
// Commit-trace collector: packs WB register writes (and, with TRACE_MEM_EN defined,
// MEM-stage stores) into sequenced 64-bit records and streams them out valid/ready.
module trace_collector
    import Trace_PKG::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reg_write_sig,
    input  logic [4:0]             reg_num,
    input  logic [DATA_W-1:0]      reg_data,
    input  logic                   wr,
    input  logic [DM_ADDRESS-1:0]  addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output logic [63:0]            tr_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       overflow_cnt
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef TRACE_MEM_EN
    localparam int PUSH_W = 2;
`else
    localparam int PUSH_W = 1;
`endif

    logic             reg_ev;
    logic             mem_ev;
    logic             pop;
    logic [LVL_W:0]   free;
    logic [1:0]       n_ev;
    logic [1:0]       n_push;
    logic [1:0]       n_drop;
    logic             push0;
    logic             push1;
    logic [SEQ_W-1:0] seq;
    logic [CNT_W:0]   ovf_sum;
    trace_rec_t       reg_rec;
    trace_rec_t       mem_rec;
    trace_rec_t       din0;

    assign reg_ev = reg_write_sig && (reg_num != 5'd0);
`ifdef TRACE_MEM_EN
    assign mem_ev = wr;
`else
    logic unused_wr;
    assign unused_wr = wr;
    assign mem_ev    = 1'b0;
`endif

    assign pop  = tr_valid && tr_ready;
    // A pop in the same edge frees its slot for an incoming event.
    assign free = (LVL_W+1)'(DEPTH) - {1'b0, fifo_level} + (LVL_W+1)'(pop);

    assign n_ev   = {1'b0, reg_ev} + {1'b0, mem_ev};
    assign push0  = (n_ev != 2'd0) && (free != '0);
    assign push1  = (n_ev == 2'd2) && (free >= (LVL_W+1)'(2));
    assign n_push = {1'b0, push0} + {1'b0, push1};
    assign n_drop = n_ev - n_push;

    // Reg record is the older instruction, so it takes seq first.
    always_comb begin
        reg_rec = make_rec(TR_REG, seq, (48'(reg_num) << 32) | 48'(reg_data));
        mem_rec = make_rec(TR_MEM, seq + SEQ_W'(reg_ev), (48'(addr) << 32) | 48'(wr_data));
        din0    = reg_ev ? reg_rec : mem_rec;
    end

    assign ovf_sum = {1'b0, overflow_cnt} + (CNT_W+1)'(n_drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq          <= '0;
            overflow_cnt <= '0;
        end else begin
            seq          <= seq + SEQ_W'(n_ev);
            overflow_cnt <= ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
        end
    end

    trace_fifo #(
        .DEPTH  (DEPTH),
        .W      (64),
        .PUSH_W (PUSH_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .push1 (push1),
        .din0  (din0),
        .din1  (mem_rec),
        .pop   (pop),
        .dout  (tr_data),
        .valid (tr_valid),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_trace_collector.sv
// Scoreboard bench for trace_collector; expectations follow TRACE_MEM_EN when defined.
module tb_trace_collector;

    logic        clk;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic        tr_valid;
    logic        tr_ready;
    logic [63:0] tr_data;
    logic [3:0]  fifo_level;
    logic [15:0] overflow_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    trace_collector #(
        .DATA_W     (32),
        .DM_ADDRESS (9),
        .DEPTH      (8),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .addr          (addr),
        .wr_data       (wr_data),
        .tr_valid      (tr_valid),
        .tr_ready      (tr_ready),
        .tr_data       (tr_data),
        .fifo_level    (fifo_level),
        .overflow_cnt  (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rrec(input int s, input logic [4:0] r, input logic [31:0] d);
        return {2'b01, s[13:0], 11'b0, r, d};
    endfunction

    // Monitor: every handshake must match the oldest expected record.
    always @(negedge clk) begin
        if (reset && tr_valid && tr_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_record: got %h expected none", tr_data);
            end else begin
                chk("record", tr_data, exp_q.pop_front());
            end
        end
    end

    task automatic ev(input logic rs, input logic [4:0] rn, input logic [31:0] rd,
                      input logic w, input logic [8:0] a, input logic [31:0] wd);
        reg_write_sig = rs;
        reg_num       = rn;
        reg_data      = rd;
        wr            = w;
        addr          = a;
        wr_data       = wd;
        @(posedge clk);
        #1;
        reg_write_sig = 1'b0;
        reg_num       = '0;
        reg_data      = '0;
        wr            = 1'b0;
        addr          = '0;
        wr_data       = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        tr_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (fifo_level == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_level", 64'(fifo_level), 64'd0);
        tr_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(tr_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf", 64'(overflow_cnt), 64'd0);
        chk("rst_data", tr_data, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        reg_write_sig = 1'b0;
        reg_num       = '0;
        reg_data      = '0;
        wr            = 1'b0;
        addr          = '0;
        wr_data       = '0;
        tr_ready      = 1'b0;
        idle(2);
        chk("init_valid", 64'(tr_valid), 64'd0);
        chk("init_data", tr_data, 64'd0);
        chk("init_level", 64'(fifo_level), 64'd0);
        chk("init_ovf", 64'(overflow_cnt), 64'd0);
        reset = 1'b1;

        // single write x5, one-cycle latency
        ev(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0);
        chk("x5_valid", 64'(tr_valid), 64'd1);
        chk("x5_data", tr_data, 64'h4000_0005_DEAD_BEEF);
        chk("x5_level", 64'(fifo_level), 64'd1);
        exp_q.push_back(64'h4000_0005_DEAD_BEEF);
        drain(4);

        // x0 filtered, does not consume a sequence number
        pulse_reset();
        tr_ready = 1'b1;
        ev(1, 5'd0, 32'h1234, 0, '0, '0);
        chk("x0_valid", 64'(tr_valid), 64'd0);
        chk("x0_level", 64'(fifo_level), 64'd0);
        exp_q.push_back(64'h4000_0001_0000_0001);
        ev(1, 5'd1, 32'h1, 0, '0, '0);
        idle(2);
        chk("x1_level", 64'(fifo_level), 64'd0);
        tr_ready = 1'b0;

        // simultaneous reg and store
        pulse_reset();
`ifdef TRACE_MEM_EN
        exp_q.push_back(64'h4000_0003_0000_0011);
        exp_q.push_back(64'h8001_001C_0000_0022);
        ev(1, 5'd3, 32'h11, 1, 9'h01C, 32'h22);
        chk("dual_level", 64'(fifo_level), 64'd2);
        drain(4);
        exp_q.push_back(64'h8002_0040_0000_0055);
        ev(0, 5'd0, '0, 1, 9'h040, 32'h55);
        chk("store_level", 64'(fifo_level), 64'd1);
        drain(4);
`else
        exp_q.push_back(64'h4000_0003_0000_0011);
        ev(1, 5'd3, 32'h11, 1, 9'h01C, 32'h22);
        chk("dual_level", 64'(fifo_level), 64'd1);
        drain(4);
        ev(0, 5'd0, '0, 1, 9'h040, 32'h55);
        chk("store_ignored", 64'(fifo_level), 64'd0);
        exp_q.push_back(64'h4001_0001_0000_0007);
        ev(1, 5'd1, 32'h7, 0, '0, '0);
        drain(4);
`endif

        // overflow with tr_ready low
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back(rrec(i, 5'(i + 1), 32'h100 + i));
            ev(1, 5'(i + 1), 32'h100 + i, 0, '0, '0);
        end
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_cnt", 64'(overflow_cnt), 64'd2);
        drain(12);
        exp_q.push_back(64'h400A_0007_0000_00AA);
        ev(1, 5'd7, 32'hAA, 0, '0, '0);
        drain(4);

        // full FIFO streaming with tr_ready high
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(rrec(i, 5'(i + 1), 32'h200 + i));
            ev(1, 5'(i + 1), 32'h200 + i, 0, '0, '0);
        end
        tr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(rrec(8 + i, 5'((i % 31) + 1), 32'h300 + i));
            ev(1, 5'((i % 31) + 1), 32'h300 + i, 0, '0, '0);
            chk("stream_level", 64'(fifo_level), 64'd8);
        end
        chk("stream_ovf", 64'(overflow_cnt), 64'd0);
`ifdef TRACE_MEM_EN
        exp_q.push_back(rrec(28, 5'd4, 32'h33));
        ev(1, 5'd4, 32'h33, 1, 9'h010, 32'h44);
        chk("full_dual_level", 64'(fifo_level), 64'd8);
        chk("full_dual_ovf", 64'(overflow_cnt), 64'd1);
`endif
        drain(12);

        // async reset mid-operation at level 5
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back(rrec(i, 5'd9, 32'h400 + i));
            ev(1, 5'd9, 32'h400 + i, 0, '0, '0);
        end
        tr_ready = 1'b1;
        idle(3);
        tr_ready = 1'b0;
        chk("pre_rst_level", 64'(fifo_level), 64'd5);
        chk("pre_rst_ovf", 64'(overflow_cnt), 64'd2);
        pulse_reset();
        exp_q.push_back(64'h4000_0002_0000_0005);
        ev(1, 5'd2, 32'h5, 0, '0, '0);
        chk("post_rst_data", tr_data, 64'h4000_0002_0000_0005);
        drain(4);

        idle(2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_collector.md
# trace_collector

Commit-trace collector on the receiving end of the pipeline's debug outputs. It consumes the write-back register-write strobe (reg_write_sig/reg_num/reg_data) and the MEM-stage store strobe (wr/addr/wr_data). Each qualifying event is packed into a 64-bit sequenced record and buffered in a small FIFO. A valid/ready stream drains the FIFO toward a testbench scoreboard or an off-chip trace port.

## Interface
Parameters:
- DATA_W, 32, register/store data width
- DM_ADDRESS, 9, data-memory byte-address width
- DEPTH, 8, FIFO entries (power of two, ≥2)
- CNT_W, 16, overflow counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (reset==0 clears all state immediately)
- reg_write_sig  in  1  WB-stage register write strobe
- reg_num  in  5  destination register
- reg_data  in  DATA_W  value written
- wr  in  1  MEM-stage store strobe
- addr  in  DM_ADDRESS  store byte address
- wr_data  in  DATA_W  store data
- tr_valid  out  1  head record available
- tr_ready  in  1  consumer accepts head
- tr_data  out  64  head record
- fifo_level  out  $clog2(DEPTH)+1  occupied entries
- overflow_cnt  out  CNT_W  dropped-event count, saturating

## Operation
- Reg event: reg_write_sig==1 && reg_num!=0. Writes to x0 are filtered: no record, no sequence increment.
- Mem event: wr==1.
- Record layout:
  - [63:62] type: 01 = reg, 10 = mem.
  - [61:48] seq[13:0].
  - Reg record: [47:37]=0, [36:32]=reg_num, [31:0]=reg_data.
  - Mem record: [47:41]=0, [40:32]=addr, [31:0]=wr_data.
- Sequence counter: 14 bits, wraps 16383→0. Incremented once per qualifying event, including dropped events, so seq gaps expose drops.
- Simultaneous reg and mem events in one cycle:
  - Reg record is ordered first (older instruction) and takes seq=S.
  - Mem record takes S+1; the counter advances by 2.
- Pop: occurs when tr_valid && tr_ready. tr_valid = (fifo_level!=0).
- Free slots for this cycle = DEPTH − fifo_level + pop. A same-cycle pop makes room.
- Overflow:
  - Events are pushed in order while free slots remain; the remainder is dropped.
  - overflow_cnt += dropped count (0, 1 or 2), saturating at all-ones.
- fifo_level' = fifo_level + pushed − pop.
- tr_data presents the head entry and holds stable while tr_valid && !tr_ready. Value when tr_valid==0 is 0.

## Timing
- Reset values: tr_valid=0, tr_data=0, fifo_level=0, overflow_cnt=0, seq=0, FIFO pointers=0.
- Reset is asserted asynchronously mid-operation. All buffered records and counters are discarded; events sampled in the deassertion cycle's edge are ignored.
- Latency: an event sampled at edge N into an empty FIFO gives tr_valid=1 and the record on tr_data after edge N. There is no combinational input→output path.
- Full FIFO with tr_ready=1 and one event: pop and push in the same edge, no drop, fifo_level unchanged.
- Full FIFO with tr_ready=1 and two events: reg pushed, mem dropped, overflow_cnt+1.
- Empty FIFO with tr_ready=1: no pop, level stays 0, no underflow.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Configuration
- TRACE_MEM_EN:
  - Defined: mem events are captured as above.
  - Undefined:
    - wr/addr/wr_data are ported but ignored.
    - Only reg records are generated, and the FIFO is built single-push.
    - Type 10 never appears.
    - overflow_cnt increments by at most 1 per cycle.

## Structure
- Shared package Trace_PKG:
  - trace_rec_t packed struct (type, seq, payload).
  - Constants TR_REG=2'b01, TR_MEM=2'b10, SEQ_W=14.
- One sub-module, trace_fifo: dual-push/single-pop FIFO parameterised by DEPTH and push width.
- Top level holds event qualification, record packing, seq and overflow counters.

## Test plan
- Reset, then single write x5=0xDEADBEEF → next cycle tr_valid=1, tr_data=0x4000_0005_DEAD_BEEF, fifo_level=1.
- Write to x0 with value 0x1234 and tr_ready=1 → tr_valid stays 0; next write x1=0x1 carries seq=0.
- Same cycle: reg x3=0x11 and store addr=0x1C data=0x22 (TRACE_MEM_EN) → records seq 0 type 01 then seq 1 type 10 with [40:32]=0x1C, in that order.
- tr_ready=0 with 10 single reg events, DEPTH=8 → fifo_level=8, overflow_cnt=2. Drained records show seq 0..7; the next accepted event has seq=10.
- Full FIFO with tr_ready=1, one event per cycle for 20 cycles → no drops, fifo_level constant 8, seq contiguous.
- Reset pulsed low for one cycle while fifo_level=5 → tr_valid=0, fifo_level=0, overflow_cnt=0 immediately (before the next edge); seq restarts at 0.
